// File: rtl/scratch_pad_dma_pkg.sv
// Shared scratch pad constants: geometry, byte packing offset and the burst engine state type.
package pkg_scratch_pad;

    localparam int InDWidth   = 8;
    localparam int Depth      = 4096;
    localparam int SramDepth  = 1024;
    localparam int Index      = $clog2(Depth);
    localparam int PackOffset = 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT,
        DONE
    } dma_state_e;

endpackage

// File: rtl/scratch_pad_dma_if.sv
// Core-side scratch pad port; the burst engine drives it as master, the pad answers as slave.
interface scratch_pad_dma_if #(
    parameter int DWidth = 32
);
    logic              request;
    logic [DWidth-1:0] addr;
    logic              write;
    logic [DWidth-1:0] write_data;
    logic [DWidth-1:0] read_data;
    logic              ready;

    modport master (
        output request, addr, write, write_data,
        input  read_data, ready
    );

    modport slave (
        input  request, addr, write, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/scratch_pad_dma.sv
// Burst initiator: streams bytes into consecutive scratch pad words, or fetches words back
// out as a byte stream, one element per pad access.
module scratch_pad_dma
    import pkg_scratch_pad::*;
#(
    parameter int DWidth   = 32,
    parameter int LenWidth = 13
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [DWidth-1:0]   cmd_base_addr_i,
    input  logic [LenWidth-1:0] cmd_len_i,
    input  logic                wr_valid_i,
    input  logic [InDWidth-1:0] wr_data_i,
    output logic                wr_ready_o,
    output logic                rd_valid_o,
    output logic [InDWidth-1:0] rd_data_o,
    input  logic                rd_ready_i,
    scratch_pad_dma_if.master   sp,
    output logic                busy_o,
    output logic                done_o
);

    localparam int AddrLsb = 2;
    localparam int WordMsb = Index + AddrLsb - 1;

    dma_state_e          state_q, state_d;
    logic                write_q, write_d;
    logic [DWidth-1:0]   addr_q, addr_d;
    logic [LenWidth-1:0] cnt_q, cnt_d;
    logic [InDWidth-1:0] rd_data_q, rd_data_d;
    logic                advance;

    logic unused_bits;
    assign unused_bits = ^{cmd_base_addr_i[AddrLsb-1:0],
                           sp.read_data[DWidth-1:PackOffset+InDWidth],
                           sp.read_data[PackOffset-1:0]};

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    write_d = cmd_write_i;
                    addr_d  = {cmd_base_addr_i[DWidth-1:AddrLsb], {AddrLsb{1'b0}}};
                    cnt_d   = cmd_len_i;
                    state_d = (cmd_len_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!write_q || wr_valid_i) state_d = WAIT;
            end
            WAIT: begin
                if (sp.ready) begin
                    if (write_q) begin
                        advance = 1'b1;
                    end else begin
                        rd_data_d = sp.read_data[PackOffset +: InDWidth];
                        state_d   = OUT;
                    end
                end
            end
            OUT: begin
                if (rd_ready_i) advance = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Only the word index counts, so the address wraps inside the pad and keeps the upper base bits.
        if (advance) begin
            cnt_d                   = cnt_q - LenWidth'(1);
            addr_d[WordMsb:AddrLsb] = addr_q[WordMsb:AddrLsb] + Index'(1);
            state_d                 = (cnt_q == LenWidth'(1)) ? DONE : ISSUE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Address and direction stay on the bus through WAIT because the pad decodes the live address.
    always_comb begin
        cmd_ready_o   = 1'b0;
        wr_ready_o    = 1'b0;
        rd_valid_o    = 1'b0;
        rd_data_o     = '0;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        sp.request    = 1'b0;
        sp.addr       = '0;
        sp.write      = 1'b0;
        sp.write_data = '0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            ISSUE: begin
                sp.addr  = addr_q;
                sp.write = write_q;
                if (write_q) begin
                    sp.request = wr_valid_i;
                    wr_ready_o = wr_valid_i;
                    if (wr_valid_i) sp.write_data[PackOffset +: InDWidth] = wr_data_i;
                end else begin
                    sp.request = 1'b1;
                end
            end
            WAIT: begin
                sp.addr  = addr_q;
                sp.write = write_q;
            end
            OUT: begin
                rd_valid_o = 1'b1;
                rd_data_o  = rd_data_q;
            end
            DONE: done_o = 1'b1;
            default: busy_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_scratch_pad_dma.sv
// Randomised and directed bench for scratch_pad_dma against a behavioural pad and transfer model.
module tb_scratch_pad_dma;

    localparam int DW = 32;
    localparam int LW = 13;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  b;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [DW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [7:0]    wr_data;
    logic          rd_valid, rd_ready;
    logic [7:0]    rd_data;
    logic          busy, done;

    always #5 clk = ~clk;

    scratch_pad_dma_if #(.DWidth(DW)) sp_bus ();

    scratch_pad_dma #(.DWidth(DW), .LenWidth(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_base_addr_i(cmd_base), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_ready_i(rd_ready),
        .sp(sp_bus),
        .busy_o(busy), .done_o(done)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [7:0]  ref_mem [4096];
    req_t        exp_req[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  wr_q[$];
    logic [7:0]  no_bytes[$];
    logic [7:0]  t1_bytes[$];
    logic        cur_write = 1'b0;

    int          req_cyc[$];
    logic [31:0] req_addr_log[$];
    logic [31:0] wdata_log[$];
    logic [7:0]  rd_log[$];
    int          rd_cyc[$];
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;

    int wr_prob = 100;
    int wr_hold = 0;
    int rd_mode = 0;
    int lat_min = 0;
    int lat_max = 0;

    logic [31:0] lit_wd[4] = '{32'h22, 32'h44, 32'h66, 32'h88};
    logic [7:0]  lit_rd[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Behavioural pad: write on request, ready after a random latency, read data from the live address.
    logic [31:0] pad_mem [4096];
    logic        pend = 1'b0;
    logic        rdy = 1'b0;
    int          pcnt = 0;
    int          pad_lat;
    logic        mem_init_done = 1'b0;

    assign sp_bus.ready     = rdy;
    assign sp_bus.read_data = pad_mem[sp_bus.addr[13:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
            rdy  <= 1'b0;
            pcnt <= 0;
            if (!mem_init_done) begin
                for (int i = 0; i < 4096; i++)
                    pad_mem[i] <= ($urandom() & 32'hFFFF_FE01) | {23'b0, ref_mem[i], 1'b0};
                mem_init_done <= 1'b1;
            end
        end else if (sp_bus.request) begin
            pad_lat = $urandom_range(lat_max, lat_min);
            pend <= 1'b1;
            pcnt <= pad_lat;
            rdy  <= (pad_lat == 0);
            if (sp_bus.write) pad_mem[sp_bus.addr[13:2]] <= sp_bus.write_data;
        end else if (pend && rdy) begin
            pend <= 1'b0;
            rdy  <= 1'b0;
        end else if (pend) begin
            if (pcnt <= 1) rdy <= 1'b1;
            pcnt <= pcnt - 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Write-stream source
    initial begin
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        forever begin
            @(posedge clk);
            if (wr_valid && wr_ready && wr_q.size() > 0) void'(wr_q.pop_front());
            #1;
            if (wr_hold > 0) begin
                wr_hold--;
                wr_valid = 1'b0;
            end else if (wr_q.size() > 0 && $urandom_range(99, 0) < wr_prob) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom());
            end
        end
    end

    // Read-stream sink
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rd_mode == 0)      rd_ready = 1'b1;
            else if (rd_mode == 1) rd_ready = 1'($urandom_range(1, 0));
            else                   rd_ready = 1'b0;
        end
    end

    // Per-cycle compare against the transfer model
    initial begin
        req_t        e;
        logic [31:0] last_addr;
        logic        last_wr;
        logic        prev_rv;
        logic        prev_rr;
        logic [7:0]  prev_rd;
        last_addr = '0;
        last_wr   = 1'b0;
        prev_rv   = 1'b0;
        prev_rr   = 1'b0;
        prev_rd   = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_rv = 1'b0;
                continue;
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            checkOutput("cmd_ready_is_not_busy", {31'b0, cmd_ready}, {31'b0, ~busy});
            if (sp_bus.request) begin
                req_cyc.push_back(cyc);
                req_addr_log.push_back(sp_bus.addr);
                wdata_log.push_back(sp_bus.write_data);
                checkOutput("req_expected", {31'b0, exp_req.size() != 0}, 32'd1);
                if (exp_req.size() != 0) begin
                    e = exp_req.pop_front();
                    checkOutput("req_addr", sp_bus.addr, e.addr);
                    checkOutput("req_write", {31'b0, sp_bus.write}, {31'b0, e.wr});
                    checkOutput("req_wdata", sp_bus.write_data, e.wr ? {23'b0, e.b, 1'b0} : 32'h0);
                end
                checkOutput("wr_ready_with_req", {31'b0, wr_ready}, {31'b0, sp_bus.write});
                last_addr = sp_bus.addr;
                last_wr   = sp_bus.write;
            end else begin
                checkOutput("wdata_zero_no_req", sp_bus.write_data, 32'h0);
                checkOutput("wr_ready_no_req", {31'b0, wr_ready}, 32'd0);
                if (pend) begin
                    checkOutput("wait_addr_held", sp_bus.addr, last_addr);
                    checkOutput("wait_write_held", {31'b0, sp_bus.write}, {31'b0, last_wr});
                end
            end
            if (!cur_write) checkOutput("read_mode_write_low", {31'b0, sp_bus.write}, 32'd0);
            if (rd_valid) begin
                checkOutput("rd_no_req", {31'b0, sp_bus.request}, 32'd0);
                if (prev_rv && !prev_rr) checkOutput("rd_data_hold", {24'b0, rd_data}, {24'b0, prev_rd});
                if (rd_ready) begin
                    rd_log.push_back(rd_data);
                    rd_cyc.push_back(cyc);
                    checkOutput("rd_expected", {31'b0, exp_rd.size() != 0}, 32'd1);
                    if (exp_rd.size() != 0) checkOutput("rd_data", {24'b0, rd_data}, {24'b0, exp_rd.pop_front()});
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checkOutput("done_reqs_drained", exp_req.size(), 32'd0);
                checkOutput("done_rd_drained", exp_rd.size(), 32'd0);
            end
            prev_rv = rd_valid;
            prev_rr = rd_ready;
            prev_rd = rd_data;
        end
    end

    task automatic clearLogs();
        req_cyc.delete();
        req_addr_log.delete();
        wdata_log.delete();
        rd_log.delete();
        rd_cyc.delete();
    endtask

    task automatic issueCmd(input logic wr, input logic [31:0] base, input int len, input logic [7:0] bytes[$]);
        int          idx;
        logic [7:0]  b;
        req_t        r;
        for (int i = 0; i < len; i++) begin
            idx    = (int'(base[13:2]) + i) % 4096;
            r.addr = {base[31:14], 12'(idx), 2'b00};
            r.wr   = wr;
            if (wr) begin
                b = (i < bytes.size()) ? bytes[i] : 8'($urandom());
                wr_q.push_back(b);
                ref_mem[idx] = b;
                r.b = b;
            end else begin
                r.b = 8'h00;
                exp_rd.push_back(ref_mem[idx]);
            end
            exp_req.push_back(r);
        end
        cur_write = wr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = base;
        cmd_len   = LW'(len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom());
        cmd_base  = $urandom();
        cmd_len   = LW'($urandom());
    endtask

    task automatic waitDone(input string name);
        int start;
        int waited;
        start  = done_cnt;
        waited = 0;
        while (done_cnt == start && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, "_done_once"}, done_cnt - start, 32'd1);
        @(negedge clk);
        checkOutput({name, "_idle_after"}, {30'b0, busy, cmd_ready}, 32'd1);
        checkOutput({name, "_wr_drained"}, wr_q.size(), 32'd0);
    endtask

    task automatic applyStimulus(input string name, input logic wr, input logic [31:0] base, input int len,
                                 input int wprob, input int rmode, input logic [7:0] bytes[$]);
        wr_prob = wprob;
        rd_mode = rmode;
        issueCmd(wr, base, len, bytes);
        waitDone(name);
    endtask

    logic        r_wr;
    logic [31:0] r_base;
    int          r_len;
    int          w;
    int          d0;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom());

        // Reset state
        @(negedge clk);
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_req", {31'b0, sp_bus.request}, 32'd0);
        checkOutput("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        checkOutput("rst_addr", sp_bus.addr, 32'd0);
        checkOutput("rst_wdata", sp_bus.write_data, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1: four-element write burst
        lat_min = 0;
        lat_max = 0;
        t1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        clearLogs();
        applyStimulus("t1", 1'b1, 32'h0, 4, 100, 0, t1_bytes);
        checkOutput("t1_nreq", req_cyc.size(), 32'd4);
        for (int i = 0; i < 4 && i < req_cyc.size(); i++) begin
            checkOutput("t1_wdata_lit", wdata_log[i], lit_wd[i]);
            checkOutput("t1_addr_lit", req_addr_log[i], 32'(4 * i));
            checkOutput("t1_req_cycle", req_cyc[i] - acc_cyc, 32'(1 + 2 * i));
        end
        checkOutput("t1_done_cycle", done_cyc - acc_cyc, 32'd9);

        // Test 2: read the same words back
        clearLogs();
        applyStimulus("t2", 1'b0, 32'h0, 4, 100, 0, no_bytes);
        checkOutput("t2_nrd", rd_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            checkOutput("t2_rd_lit", {24'b0, rd_log[i]}, {24'b0, lit_rd[i]});
            checkOutput("t2_rd_cycle", rd_cyc[i] - acc_cyc, 32'(3 * (i + 1)));
        end
        checkOutput("t2_done_cycle", done_cyc - acc_cyc, 32'd13);

        // Test 3: backpressure in OUT
        clearLogs();
        rd_mode = 2;
        issueCmd(1'b0, 32'h40, 2, no_bytes);
        w = 0;
        while (!rd_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("t3_reach_out", {31'b0, rd_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_valid_held", {31'b0, rd_valid}, 32'd1);
            checkOutput("t3_data_held", {24'b0, rd_data}, {24'b0, ref_mem[16]});
            checkOutput("t3_no_req", {31'b0, sp_bus.request}, 32'd0);
            @(negedge clk);
        end
        rd_mode = 0;
        waitDone("t3");
        checkOutput("t3_second_addr", (req_addr_log.size() == 2) ? req_addr_log[1] : 32'hDEAD, 32'h44);

        // Test 4: address boundaries and a gapped write stream
        clearLogs();
        applyStimulus("t4_bank", 1'b0, 32'h0FFC, 2, 100, 0, no_bytes);
        checkOutput("t4_bank_a1", (req_addr_log.size() == 2) ? req_addr_log[1] : 32'hDEAD, 32'h1000);
        clearLogs();
        applyStimulus("t4_wrap", 1'b1, 32'h3FFC, 2, 100, 0, no_bytes);
        checkOutput("t4_wrap_a0", (req_addr_log.size() == 2) ? req_addr_log[0] : 32'hDEAD, 32'h3FFC);
        checkOutput("t4_wrap_a1", (req_addr_log.size() == 2) ? req_addr_log[1] : 32'hDEAD, 32'h0);
        clearLogs();
        applyStimulus("t4_high", 1'b1, 32'h1234_7FFE, 2, 100, 0, no_bytes);
        checkOutput("t4_high_a1", (req_addr_log.size() == 2) ? req_addr_log[1] : 32'hDEAD, 32'h1234_4000);
        clearLogs();
        wr_prob = 100;
        issueCmd(1'b1, 32'h200, 2, no_bytes);
        w = 0;
        while (!sp_bus.request && w < 50) begin
            @(negedge clk);
            w++;
        end
        wr_hold = 4;
        waitDone("t4_gap");
        checkOutput("t4_gap_spacing", (req_cyc.size() == 2) ? req_cyc[1] - req_cyc[0] : 0, 32'd5);

        // Test 5: zero length and commands offered while busy
        clearLogs();
        d0 = done_cnt;
        issueCmd(1'b1, 32'h80, 0, no_bytes);
        @(negedge clk);
        checkOutput("t5_done_pulse", {31'b0, done}, 32'd1);
        checkOutput("t5_not_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        checkOutput("t5_ready_again", {31'b0, cmd_ready}, 32'd1);
        checkOutput("t5_done_low", {31'b0, done}, 32'd0);
        checkOutput("t5_one_done", done_cnt - d0, 32'd1);
        checkOutput("t5_no_req", req_cyc.size(), 32'd0);
        issueCmd(1'b0, 32'h300, 3, no_bytes);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_len   = LW'(5);
        repeat (3) @(posedge clk);
        #1 cmd_valid = 1'b0;
        waitDone("t5_busy");

        // Test 6: reset while waiting on a read
        lat_min = 2;
        lat_max = 2;
        issueCmd(1'b0, 32'h100, 3, no_bytes);
        w = 0;
        while (!(pend && !sp_bus.request) && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("t6_in_wait", {31'b0, pend}, 32'd1);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_req.delete();
        exp_rd.delete();
        wr_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_busy", {31'b0, busy}, 32'd0);
        checkOutput("t6_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("t6_rd_valid", {31'b0, rd_valid}, 32'd0);
        checkOutput("t6_req", {31'b0, sp_bus.request}, 32'd0);
        checkOutput("t6_addr", sp_bus.addr, 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("t6_no_done", done_cnt - d0, 32'd0);
        applyStimulus("t6_after", 1'b0, 32'h100, 3, 100, 1, no_bytes);

        // Randomised commands
        lat_min = 0;
        lat_max = 2;
        for (int k = 0; k < 40; k++) begin
            r_wr   = 1'($urandom_range(1, 0));
            r_base = $urandom();
            if ($urandom_range(3, 0) == 0) r_base[13:2] = 12'hFFE;
            r_len  = $urandom_range(6, 0);
            applyStimulus("rand", r_wr, r_base, r_len, $urandom_range(100, 30), $urandom_range(1, 0), no_bytes);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scratch_pad_dma.md
Name: scratch_pad_dma

Overview:
Burst initiator that drives the scratch pad's core-side port (request/addr/write/write_data; returns ready/read_data) in place of the scalar core. It accepts a command of base address, length and direction. In write mode it drains a byte stream into consecutive scratch pad words. In read mode it fetches consecutive words and presents them as a byte stream with valid/ready backpressure. It sits between the MLP datapath streams and the scratch pad.

Parameters:
DWidth, 32, width of scratch pad address/data bus
LenWidth, 13, width of element count (max 4096 = full pad)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  command accepted when both high
cmd_write_i  in  1  1 = stream-to-pad, 0 = pad-to-stream
cmd_base_addr_i  in  DWidth  byte address of first element; bits [1:0] ignored
cmd_len_i  in  LenWidth  number of elements
wr_valid_i  in  1  write byte valid
wr_data_i  in  8  write byte
wr_ready_o  out  1  write byte consumed
rd_valid_o  out  1  read byte valid
rd_data_o  out  8  read byte
rd_ready_i  in  1  read byte consumed
sp_request_o  out  1  to pad request
sp_addr_o  out  DWidth  to pad addr_i
sp_write_o  out  1  to pad write_i
sp_write_data_o  out  DWidth  to pad write_data_i
sp_read_data_i  in  DWidth  from pad read_data_o
sp_ready_i  in  1  from pad ready_o
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (rst_ni low at posedge): state IDLE; all outputs 0 except cmd_ready_o=1. Counters, address and read buffer cleared. A reset mid-command aborts it: no done pulse, and buffered read data is discarded.
- States: IDLE, ISSUE, WAIT, OUT, DONE.
- IDLE: cmd_ready_o=1. On accept, latch the direction, addr = base with [1:0]=0, and cnt = len.
  - len==0 goes to DONE.
  - Otherwise goes to ISSUE.
- ISSUE: sp_request_o=1, sp_addr_o=addr, sp_write_o=mode.
  - Write mode: sp_request_o and wr_ready_o are both asserted only while wr_valid_i=1. The byte is taken in the same cycle. sp_write_data_o = {(DWidth-9) zeros, wr_data_i, 1'b0}. The state stays in ISSUE until wr_valid_i.
  - Read mode: the request is unconditional. Go to WAIT.
- WAIT: sp_request_o=0. sp_addr_o and sp_write_o are held at their ISSUE values, because the pad's read mux decodes the live address.
  - Remain in WAIT until sp_ready_i=1.
  - Read mode: capture sp_read_data_i[8:1] into the output register, then go to OUT.
  - Write mode: decrement cnt and add 4 to addr. If cnt was 1 go to DONE, else go to ISSUE.
- OUT (read only): rd_valid_o=1, with rd_data_o stable. No pad request is issued.
  - On rd_ready_i: decrement cnt and add 4 to addr. If cnt was 1 go to DONE, else go to ISSUE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- cmd_valid_i is ignored when not in IDLE.
- Address increment:
  - Only bits [13:2] count, i.e. 4 banks × 1024 words.
  - Bits [13:2] wrap 0x3FFC → 0x0000.
  - Bits above [13] stay at the base value.
  - The bank boundary 0x0FFC → 0x1000 is a plain increment.
- sp_write_o=0 and sp_write_data_o=0 in IDLE, DONE and any read-mode state.
- Minimum cycles per element: write 2 (ISSUE, WAIT); read 3 (ISSUE, WAIT, OUT with rd_ready_i high).

Decomposition:
- Package pkg_scratch_pad holds:
  - InDWidth=8
  - Depth=4096
  - SramDepth=1024
  - Index=$clog2(Depth)
  - The dma_state_e enum {IDLE, ISSUE, WAIT, OUT, DONE}
  - The byte pack/unpack offset constant (1).
- The scratch pad itself is updated to import these constants.
- Single flat module; no sub-module is warranted.

Test Plan:
1. Write cmd base 0x0, len 4, wr_data 0x11,0x22,0x33,0x44 with wr_valid_i held high → sp_request_o pulses every 2 cycles at addr 0x0,0x4,0x8,0xC, sp_write_data_o 0x22,0x44,0x66,0x88 → done_o 1 cycle after the last WAIT.
2. Read cmd base 0x0, len 4, rd_ready_i=1 after test 1 → rd_data_o 0x11,0x22,0x33,0x44, one element per 3 cycles; sp_write_o=0 throughout; done_o pulses once.
3. Read with rd_ready_i low for 5 cycles in OUT → rd_valid_o and rd_data_o held stable; sp_request_o stays 0; resumes with the next addr after release.
4. Boundaries: read base 0x0FFC len 2 → addrs 0x0FFC, 0x1000. Write base 0x3FFC len 2 → addrs 0x3FFC, 0x0000. Write with wr_valid_i gapped 3 cycles → no request during the gap.
5. len 0 → no sp_request_o; done_o the cycle after accept; cmd_ready_o back to 1 the cycle after that. cmd_valid_i pulsed while busy → ignored.
6. rst_ni low in WAIT of a read → next cycle: IDLE, all outputs 0, cmd_ready_o=1, no done_o. A subsequent command runs normally.
